// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one req/gnt/rvalid memory port between the core's instruction-fetch
// port and its load/store port. Arbitration is round-robin. A request that is
// presented but not granted is locked, so the selection and the muxed request
// fields cannot change until memory accepts it. Accepted transactions are
// queued by owner in issue order. Each memory response is returned to the
// port that issued the matching request, with no added latency.
//
// Parameters
//   ADDR_WIDTH       address width of all ports
//   MAX_OUTSTANDING  max accepted-but-unanswered transactions (1..8)
//
// Ports
//   clk_i, rst_i                clock; synchronous active-high reset
//   instr_req/addr, instr_gnt   fetch request side
//   instr_rvalid/rdata          fetch response side
//   data_req/addr/we/be/wdata   load/store request side
//   data_gnt                    load/store request accepted
//   data_rvalid/rdata           load/store response side (stores too)
//   mem_req/addr/we/be/wdata    muxed request to memory
//   mem_gnt/rvalid/rdata        memory handshake and in-order response
//   protocol_err_o              sticky: response arrived with nothing pending
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_WIDTH      = 16,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_req_i,
  input  logic [ADDR_WIDTH-1:0] instr_addr_i,
  output logic                  instr_gnt_o,
  output logic                  instr_rvalid_o,
  output logic [31:0]           instr_rdata_o,
  input  logic                  data_req_i,
  input  logic [ADDR_WIDTH-1:0] data_addr_i,
  input  logic                  data_we_i,
  input  logic [3:0]            data_be_i,
  input  logic [31:0]           data_wdata_i,
  output logic                  data_gnt_o,
  output logic                  data_rvalid_o,
  output logic [31:0]           data_rdata_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  protocol_err_o
);

  typedef enum logic {
    OWNER_INSTR = 1'b0,
    OWNER_DATA  = 1'b1
  } owner_e;

  localparam int PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUTSTANDING - 1);

  // Owner queue and its bookkeeping
  owner_e           fifo_q [MAX_OUTSTANDING];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0] count_q;

  // Arbitration state
  logic   lock_q;
  owner_e lock_owner_q;
  owner_e last_q;
  logic   protocol_err_q;

  logic   full, accept, push, pop;
  owner_e sel, head;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // Full is taken from the registered count, so a response popping in the
  // same cycle does not open a slot until the next cycle.
  assign full      = (count_q == CNT_MAX);
  assign mem_req_o = !full && (lock_q || instr_req_i || data_req_i);
  assign accept    = mem_req_o && mem_gnt_i;
  assign push      = accept;
  assign pop       = mem_rvalid_i && (count_q != '0);
  assign head      = fifo_q[rd_ptr_q];

  // NOTE: every combinational output gets a default before any branch, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    sel = OWNER_INSTR;
    if (lock_q)                          sel = lock_owner_q;
    else if (instr_req_i && !data_req_i) sel = OWNER_INSTR;
    else if (data_req_i && !instr_req_i) sel = OWNER_DATA;
    else if (last_q == OWNER_INSTR)      sel = OWNER_DATA;
    else                                 sel = OWNER_INSTR;
  end

  // Muxed request fields are forced to zero whenever no request is driven,
  // so an idle port shows all-zero outputs.
  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = 4'h0;
    mem_wdata_o = '0;
    if (mem_req_o) begin
      if (sel == OWNER_DATA) begin
        mem_addr_o  = data_addr_i;
        mem_we_o    = data_we_i;
        mem_be_o    = data_be_i;
        mem_wdata_o = data_wdata_i;
      end else begin
        mem_addr_o  = instr_addr_i;
        mem_be_o    = 4'hF;
      end
    end
  end

  assign instr_gnt_o    = accept && (sel == OWNER_INSTR);
  assign data_gnt_o     = accept && (sel == OWNER_DATA);
  assign instr_rvalid_o = pop && (head == OWNER_INSTR);
  assign data_rvalid_o  = pop && (head == OWNER_DATA);
  assign instr_rdata_o  = mem_rdata_i;
  assign data_rdata_o   = mem_rdata_i;
  assign protocol_err_o = protocol_err_q;

  // NOTE: the queue storage has no reset; validity is carried by count and
  // the pointers, so clearing those is enough to discard stale entries.
  always_ff @(posedge clk_i) begin
    if (push) fifo_q[wr_ptr_q] <= sel;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      lock_q         <= 1'b0;
      lock_owner_q   <= OWNER_INSTR;
      last_q         <= OWNER_INSTR;  // data wins the first tie
      protocol_err_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);

      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase

      if (accept) begin
        lock_q <= 1'b0;
        last_q <= sel;
      end else if (mem_req_o) begin
        lock_q       <= 1'b1;
        lock_owner_q <= sel;
      end

      if (mem_rvalid_i && (count_q == '0)) protocol_err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed bench for mem_port_arbiter (ADDR_WIDTH=16, MAX_OUTSTANDING=2).
// Inputs change just after each falling edge; combinational outputs are
// compared 1 ns later, well away from the rising edge that commits state.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        instr_req_i;
  logic [15:0] instr_addr_i;
  logic        instr_gnt_o, instr_rvalid_o;
  logic [31:0] instr_rdata_o;
  logic        data_req_i;
  logic [15:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_gnt_o, data_rvalid_o;
  logic [31:0] data_rdata_o;
  logic        mem_req_o;
  logic [15:0] mem_addr_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        protocol_err_o;

  int checks = 0;
  int errors = 0;

  mem_port_arbiter #(.ADDR_WIDTH(16), .MAX_OUTSTANDING(2)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .instr_req_i(instr_req_i), .instr_addr_i(instr_addr_i),
    .instr_gnt_o(instr_gnt_o), .instr_rvalid_o(instr_rvalid_o),
    .instr_rdata_o(instr_rdata_o),
    .data_req_i(data_req_i), .data_addr_i(data_addr_i), .data_we_i(data_we_i),
    .data_be_i(data_be_i), .data_wdata_i(data_wdata_i),
    .data_gnt_o(data_gnt_o), .data_rvalid_o(data_rvalid_o),
    .data_rdata_o(data_rdata_o),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o),
    .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .protocol_err_o(protocol_err_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    instr_req_i  = 1'b0; instr_addr_i = '0;
    data_req_i   = 1'b0; data_addr_i  = '0; data_we_i = 1'b0;
    data_be_i    = 4'h0; data_wdata_i = '0;
    mem_gnt_i    = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
  endtask

  task automatic next();
    @(negedge clk_i);
  endtask

  initial begin
    // ---------------- reset state ----------------
    idle(); rst_i = 1'b1;
    next(); next();
    rst_i = 1'b0; #1;
    chk("rst_mem_req",   mem_req_o,      0);
    chk("rst_i_gnt",     instr_gnt_o,    0);
    chk("rst_d_gnt",     data_gnt_o,     0);
    chk("rst_i_rvalid",  instr_rvalid_o, 0);
    chk("rst_d_rvalid",  data_rvalid_o,  0);
    chk("rst_err",       protocol_err_o, 0);
    chk("rst_addr",      mem_addr_o,     0);
    chk("rst_be",        mem_be_o,       0);
    chk("rst_we",        mem_we_o,       0);
    chk("rst_wdata",     mem_wdata_o,    0);

    // ---------------- single fetch ----------------
    next(); idle();
    instr_req_i = 1'b1; instr_addr_i = 16'h0080; mem_gnt_i = 1'b1; #1;
    chk("t1_i_gnt",  instr_gnt_o, 1);
    chk("t1_d_gnt",  data_gnt_o,  0);
    chk("t1_addr",   mem_addr_o,  16'h0080);
    chk("t1_be",     mem_be_o,    4'hF);
    chk("t1_we",     mem_we_o,    0);
    next(); idle();
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hDEADBEEF; #1;
    chk("t1_i_rvalid", instr_rvalid_o, 1);
    chk("t1_d_rvalid", data_rvalid_o,  0);
    chk("t1_i_rdata",  instr_rdata_o,  32'hDEADBEEF);

    // ---------------- alternation from reset ----------------
    next(); idle(); rst_i = 1'b1;
    next(); rst_i = 1'b0;
    instr_req_i = 1'b1; instr_addr_i = 16'h0100;
    data_req_i  = 1'b1; data_addr_i  = 16'h0200; data_be_i = 4'hF;
    mem_gnt_i   = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mem_rvalid_i = (k != 0);
      mem_rdata_i  = 32'h1000 + k;
      #1;
      chk($sformatf("t2_d_gnt_%0d", k), data_gnt_o,  (k % 2 == 0));
      chk($sformatf("t2_i_gnt_%0d", k), instr_gnt_o, (k % 2 == 1));
      chk($sformatf("t2_addr_%0d", k),  mem_addr_o,  (k % 2 == 0) ? 16'h0200 : 16'h0100);
      if (k > 0) begin
        // Response k answers grant k-1 (push and pop together at count 1).
        chk($sformatf("t2_d_rvalid_%0d", k), data_rvalid_o,  (k % 2 == 1));
        chk($sformatf("t2_i_rvalid_%0d", k), instr_rvalid_o, (k % 2 == 0));
      end
      next();
    end
    idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h2222; #1;
    chk("t2_last_i_rvalid", instr_rvalid_o, 1);
    chk("t2_last_d_rvalid", data_rvalid_o,  0);
    chk("t2_last_rdata",    data_rdata_o,   32'h2222);

    // ---------------- locked store ----------------
    next(); idle();
    data_req_i = 1'b1; data_addr_i = 16'h0010; data_be_i = 4'hF; mem_gnt_i = 1'b1; #1;
    chk("t3_pre_d_gnt", data_gnt_o, 1);   // last granted becomes data
    next(); idle();
    data_req_i = 1'b1; data_addr_i = 16'h0040; data_we_i = 1'b1;
    data_be_i  = 4'b0011; data_wdata_i = 32'h0000CAFE;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h11; #1;
    chk("t3_pre_d_rvalid", data_rvalid_o, 1);
    chk("t3_c0_addr", mem_addr_o, 16'h0040);
    for (int k = 1; k <= 2; k++) begin
      next(); mem_rvalid_i = 1'b0;
      instr_req_i = 1'b1; instr_addr_i = 16'h0300; #1;
      // Round-robin would now favour instr; the lock must hold data.
      chk($sformatf("t3_c%0d_req", k),   mem_req_o,   1);
      chk($sformatf("t3_c%0d_addr", k),  mem_addr_o,  16'h0040);
      chk($sformatf("t3_c%0d_we", k),    mem_we_o,    1);
      chk($sformatf("t3_c%0d_be", k),    mem_be_o,    4'b0011);
      chk($sformatf("t3_c%0d_wdata", k), mem_wdata_o, 32'h0000CAFE);
      chk($sformatf("t3_c%0d_i_gnt", k), instr_gnt_o, 0);
    end
    next(); mem_gnt_i = 1'b1; #1;
    chk("t3_d_gnt",     data_gnt_o,  1);
    chk("t3_d_gnt_i",   instr_gnt_o, 0);
    next(); data_req_i = 1'b0; #1;
    chk("t3_i_gnt",     instr_gnt_o, 1);
    chk("t3_i_addr",    mem_addr_o,  16'h0300);
    chk("t3_i_be",      mem_be_o,    4'hF);
    chk("t3_i_wdata",   mem_wdata_o, 0);
    next(); idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h22; #1;
    chk("t3_r0_d", data_rvalid_o, 1);
    next(); mem_rdata_i = 32'h33; #1;
    chk("t3_r1_i", instr_rvalid_o, 1);

    // ---------------- full ----------------
    next(); idle();
    instr_req_i = 1'b1; instr_addr_i = 16'h0500; mem_gnt_i = 1'b1; #1;
    chk("t4_g0_i", instr_gnt_o, 1);
    next(); instr_req_i = 1'b0;
    data_req_i = 1'b1; data_addr_i = 16'h0600; data_be_i = 4'hF; #1;
    chk("t4_g1_d", data_gnt_o, 1);
    next(); instr_req_i = 1'b1; #1;
    chk("t4_full_req",  mem_req_o,   0);
    chk("t4_full_ig",   instr_gnt_o, 0);
    chk("t4_full_dg",   data_gnt_o,  0);
    next(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA1; #1;
    chk("t4_pop_req",   mem_req_o,      0);  // still full this cycle
    chk("t4_pop_i",     instr_rvalid_o, 1);
    chk("t4_pop_d",     data_rvalid_o,  0);
    chk("t4_pop_rdata", instr_rdata_o,  32'hA1);
    next(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b0; #1;
    chk("t4_reopen_req",  mem_req_o,  1);
    chk("t4_reopen_addr", mem_addr_o, 16'h0500);
    next(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'hA2; #1;
    chk("t4_r_d",      data_rvalid_o,  1);
    chk("t4_r_i",      instr_rvalid_o, 0);
    next(); mem_rvalid_i = 1'b0; mem_gnt_i = 1'b1; #1;
    chk("t4_g2_i",     instr_gnt_o, 1);
    chk("t4_g2_d",     data_gnt_o,  0);
    next(); idle(); mem_rvalid_i = 1'b1; #1;
    chk("t4_r2_i",     instr_rvalid_o, 1);

    // ---------------- protocol error ----------------
    next(); idle(); mem_rvalid_i = 1'b1; mem_rdata_i = 32'h55; #1;
    chk("t5_stray_i",  instr_rvalid_o, 0);
    chk("t5_stray_d",  data_rvalid_o,  0);
    next(); idle(); #1;
    chk("t5_err_set",  protocol_err_o, 1);
    next(); #1;
    chk("t5_err_hold", protocol_err_o, 1);
    next(); instr_req_i = 1'b1; mem_gnt_i = 1'b1; #1;
    chk("t5_pend_gnt", instr_gnt_o, 1);
    next(); idle(); rst_i = 1'b1;
    next(); rst_i = 1'b0; #1;
    chk("t5_err_clr",  protocol_err_o, 0);
    chk("t5_rst_req",  mem_req_o,      0);
    next(); mem_rvalid_i = 1'b1; #1;
    chk("t5_late_i",   instr_rvalid_o, 0);
    chk("t5_late_d",   data_rvalid_o,  0);
    next(); idle(); #1;
    chk("t5_late_err", protocol_err_o, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
